seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for a common-anode multi-digit 7-segment display. A single shared `decoder` instance (in[3:0] -> out[6:0], active-high segments) serves NUM_DIGITS digits, one per time slot. A blanking gap precedes each slot to suppress ghosting. New display values come in through a valid/ready load handshake and take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/decoder.sv | 32 +++
 rtl/seg7_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
//   scan_state_e : scan FSM states
//   SEG_OFF      : segment bus with every segment dark (active-low)
//   AN_OFF       : anode bus with every digit off; slice to NUM_DIGITS
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

  localparam int              MAX_DIGITS = 32;
  localparam logic [6:0]      SEG_OFF    = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

endpackage

// File: rtl/decoder.sv
// Hex nibble to 7-segment decoder, active-high segments.
//   in_i  [3:0] : hex value
//   out_o [6:0] : segments {g,f,e,d,c,b,a}, 1 = lit
module decoder (
  input  logic [3:0] in_i,
  output logic [6:0] out_o
);

  always_comb begin
    out_o = 7'h00;
    case (in_i)
      4'h0: out_o = 7'h3F;
      4'h1: out_o = 7'h06;
      4'h2: out_o = 7'h5B;
      4'h3: out_o = 7'h4F;
      4'h4: out_o = 7'h66;
      4'h5: out_o = 7'h6D;
      4'h6: out_o = 7'h7D;
      4'h7: out_o = 7'h07;
      4'h8: out_o = 7'h7F;
      4'h9: out_o = 7'h6F;
      4'hA: out_o = 7'h77;
      4'hB: out_o = 7'h7C;
      4'hC: out_o = 7'h39;
      4'hD: out_o = 7'h5E;
      4'hE: out_o = 7'h79;
      4'hF: out_o = 7'h71;
      default: out_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit
// 7-segment display. One shared decoder serves all digits; each slot
// starts with a blanking gap. New data is loaded into a shadow register
// and only promoted to the displayed set at a frame boundary (or in IDLE).
//   clk, rst_n       : clock, async active-low reset
//   en_i             : scan enable, 0 = IDLE with display dark
//   load_valid_i/load_ready_o : load handshake for digits_i/dp_i/mask_i
//   digits_i         : hex nibbles, digit k at [4k+3:4k]
//   dp_i, mask_i     : decimal points (1 = lit), digit enables (0 = dark)
//   an_n_o, seg_n_o, dp_n_o : registered active-low display drives
//   frame_done_o     : one-cycle pulse after the last digit's slot
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   mask_i,
  output logic [NUM_DIGITS-1:0]   an_n_o,
  output logic [6:0]              seg_n_o,
  output logic                    dp_n_o,
  output logic                    frame_done_o
);

  localparam int CNT_W        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W        = $clog2(NUM_DIGITS);
  localparam int DRIVE_CYCLES = REFRESH_DIV - BLANK_CYCLES;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  // With no blanking the BLANK state is never entered.
  localparam scan_state_e      SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_DIGITS-1:0][3:0] dig_act_q, dig_sh_q;
  logic [NUM_DIGITS-1:0]      dp_act_q, dp_sh_q;
  logic [NUM_DIGITS-1:0]      mask_act_q, mask_sh_q;
  logic                       pend_q;

  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;
  logic                  fd_q, fd_d;
  logic                  xfer;
  logic [6:0]            dec_seg;

  // ---------------- scan FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    if (!en_i) begin
      // Abandon any frame in progress; no frame_done for a partial frame.
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SLOT_START;
          idx_d   = '0;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = SLOT_START;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              fd_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------- load / shadow ----------------
  // Promotion lines up with the edge that raises frame_done_o, so the
  // first slot of the next frame already sees the new data.
  assign xfer = fd_d || (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_act_q  <= '0;
      dp_act_q   <= '0;
      mask_act_q <= '0;
      dig_sh_q   <= '0;
      dp_sh_q    <= '0;
      mask_sh_q  <= '0;
      pend_q     <= 1'b0;
    end else if (pend_q) begin
      if (xfer) begin
        dig_act_q  <= dig_sh_q;
        dp_act_q   <= dp_sh_q;
        mask_act_q <= mask_sh_q;
        pend_q     <= 1'b0;
      end
    end else if (load_valid_i) begin
      dig_sh_q  <= digits_i;
      dp_sh_q   <= dp_i;
      mask_sh_q <= mask_i;
      pend_q    <= 1'b1;
    end
  end

  assign load_ready_o = ~pend_q;

  // ---------------- output stage ----------------
  decoder u_dec (
    .in_i  (dig_act_q[idx_q]),
    .out_o (dec_seg)
  );

  always_comb begin
    an_n_d  = AN_OFF[NUM_DIGITS-1:0];
    seg_n_d = SEG_OFF;
    dp_n_d  = 1'b1;
    // Masked digits still burn their slot so brightness stays uniform.
    if (state_q == DRIVE && mask_act_q[idx_q]) begin
      an_n_d[idx_q] = 1'b0;
      seg_n_d       = ~dec_seg;
      dp_n_d        = ~dp_act_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n_q  <= AN_OFF[NUM_DIGITS-1:0];
      seg_n_q <= SEG_OFF;
      dp_n_q  <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      fd_q    <= fd_d;
    end
  end

  assign an_n_o       = an_n_q;
  assign seg_n_o      = seg_n_q;
  assign dp_n_o       = dp_n_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: two instances share all inputs, one
// with a 2-cycle blanking gap and one with none.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;

  logic        clk, rst_n, en, valid;
  logic [15:0] digits;
  logic [3:0]  dp, mask;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dpn_a, dpn_b, fd_a, fd_b, rdy_a, rdy_b;

  int n_chk = 0;
  int n_err = 0;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .load_valid_i(valid), .load_ready_o(rdy_a),
    .digits_i(digits), .dp_i(dp), .mask_i(mask),
    .an_n_o(an_a), .seg_n_o(seg_a), .dp_n_o(dpn_a), .frame_done_o(fd_a)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .en_i(en), .load_valid_i(valid), .load_ready_o(rdy_b),
    .digits_i(digits), .dp_i(dp), .mask_i(mask),
    .an_n_o(an_b), .seg_n_o(seg_b), .dp_n_o(dpn_b), .frame_done_o(fd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Expected drives for output position p (p<0 = not yet running).
  task automatic model(input int p, input int blank, input logic [15:0] dig,
                       input logic [3:0] m, input logic [3:0] d,
                       output logic [3:0] an, output logic [6:0] seg,
                       output logic dpn, output logic fd);
    int slot, off;
    logic [3:0] one;
    an = 4'hF; seg = 7'h7F; dpn = 1'b1; fd = 1'b0;
    if (p >= 0) begin
      slot = (p / RD) % ND;
      off  = p % RD;
      fd   = ((p % (ND * RD)) == ND * RD - 1);
      one  = 4'b0001;
      if (off >= blank && m[slot]) begin
        an  = ~(one << slot);
        seg = ~seg_of(dig[slot*4 +: 4]);
        dpn = ~d[slot];
      end
    end
  endtask

  // Output seen k edges after en_i rises reflects scan position k-2.
  task automatic step(input string pfx, input int k, input logic [15:0] dig,
                      input logic [3:0] m, input logic [3:0] d);
    logic [3:0] an; logic [6:0] seg; logic dpn, fd;
    model(k - 2, 2, dig, m, d, an, seg, dpn, fd);
    chk({pfx, "_an"},  32'(an_a),  32'(an));
    chk({pfx, "_seg"}, 32'(seg_a), 32'(seg));
    chk({pfx, "_dp"},  32'(dpn_a), 32'(dpn));
    chk({pfx, "_fd"},  32'(fd_a),  32'(fd));
    model(k - 2, 0, dig, m, d, an, seg, dpn, fd);
    chk({pfx, "_nb_an"},  32'(an_b),  32'(an));
    chk({pfx, "_nb_seg"}, 32'(seg_b), 32'(seg));
    chk({pfx, "_nb_dp"},  32'(dpn_b), 32'(dpn));
    chk({pfx, "_nb_fd"},  32'(fd_b),  32'(fd));
  endtask

  task automatic chk_dark(input string pfx);
    chk({pfx, "_an"},    32'(an_a),  32'hF);
    chk({pfx, "_seg"},   32'(seg_a), 32'h7F);
    chk({pfx, "_dp"},    32'(dpn_a), 32'h1);
    chk({pfx, "_fd"},    32'(fd_a),  32'h0);
    chk({pfx, "_nb_an"}, 32'(an_b),  32'hF);
    chk({pfx, "_nb_fd"}, 32'(fd_b),  32'h0);
  endtask

  // Must be called with en low so the IDLE promotion happens.
  task automatic load(input logic [15:0] dg, input logic [3:0] m, input logic [3:0] d);
    valid = 1'b1; digits = dg; mask = m; dp = d;
    tick();
    chk("ld_busy", 32'(rdy_a), 32'h0);
    valid = 1'b0;
    tick();
    chk("ld_free", 32'(rdy_a), 32'h1);
    chk("ld_free_nb", 32'(rdy_b), 32'h1);
  endtask

  task automatic stop_scan();
    en = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; valid = 1'b0;
    digits = '0; dp = '0; mask = '0;
    #12;
    chk_dark("rst");
    chk("rst_rdy", 32'(rdy_a), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset asserted in the middle of a drive cycle.
    load(16'h3210, 4'hF, 4'h0);
    en = 1'b1;
    repeat (6) tick();
    chk("pre_rst_an", 32'(an_a), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    chk_dark("arst");
    chk("arst_rdy", 32'(rdy_a), 32'h1);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_dark("idle");
    end

    // Scan order, decode and frame pulse spacing.
    load(16'h3210, 4'hF, 4'h0);
    en = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      step("scan", k, 16'h3210, 4'hF, 4'h0);
      if (k >= 2) chk("scan_nb_lit", 32'(an_b != 4'hF), 32'h1);
    end
    stop_scan();

    // Frame-atomic load.
    load(16'h1111, 4'hF, 4'h0);
    en = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      step("atom", k, (k - 2 < 32) ? 16'h1111 : 16'h8888, 4'hF, 4'h0);
      if (k == 10) chk("atom_rdy_pre", 32'(rdy_a), 32'h1);
      if (k == 11 || k == 32) begin
        chk("atom_rdy_busy", 32'(rdy_a), 32'h0);
        chk("atom_rdy_busy_nb", 32'(rdy_b), 32'h0);
      end
      if (k == 33) begin
        chk("atom_rdy_free", 32'(rdy_a), 32'h1);
        chk("atom_rdy_free_nb", 32'(rdy_b), 32'h1);
      end
      if (k == 10) begin valid = 1'b1; digits = 16'h8888; end
      if (k == 11) valid = 1'b0;
    end
    chk("atom_all_lit", 32'(seg_a == 7'h00 || seg_a == 7'h7F), 32'h1);
    stop_scan();

    // Masking and decimal point.
    load(16'h3210, 4'b0101, 4'b0100);
    en = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      tick();
      step("mask", k, 16'h3210, 4'b0101, 4'b0100);
      chk("mask_an13", 32'({an_a[3], an_a[1]}), 32'h3);
    end
    stop_scan();

    // Enable drop during digit 2, then restart.
    load(16'h3210, 4'hF, 4'h0);
    en = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      step("drop", k, 16'h3210, 4'hF, 4'h0);
    end
    en = 1'b0;
    tick();
    chk("drop_hold", 32'(an_a), 32'hB);
    chk("drop_hold_nb", 32'(an_b), 32'hB);
    for (int k = 23; k <= 40; k++) begin
      tick();
      chk_dark("drop_dark");
    end
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      step("restart", k, 16'h3210, 4'hF, 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
